instr_fetch_unit: RTL

//  Fetch-side initiator for the program ROM. Owns the program counter and drives the
//  ROM word address. Captures the combinational instruction word into a small
//  in-order queue. Hands {pc, instr} to decode over a valid/ready handshake.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_fetch_queue.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 50 +++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side types and constants: bus widths, ROM geometry, queue entry layout.
package instr_fetch_unit_pkg;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 256;
   localparam int RESET_PC  = 0;
   localparam int PC_W      = $clog2(MEM_DEPTH);

   // Encoding decode substitutes when it needs a bubble.
   localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fq_entry_t;

   // Fold any address onto the ROM index space.
   function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] pc);
      return pc & ADDR_W'(MEM_DEPTH - 1);
   endfunction
endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// In-order fetch queue: DEPTH-entry sync FIFO. Flush beats push; push+pop at full is legal
// because the slot being written is the one being popped.
module fetch_queue
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  logic      flush,
   input  fq_entry_t wdata,
   output fq_entry_t head,
   output logic      valid,
   output logic      full
);
   fq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_pop, do_push;

   assign valid   = (count != '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, addresses the combinational ROM and queues {pc, instr} for decode.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int Q_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] imem_pc,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc
);
   logic [PC_W-1:0] fetch_pc;
   logic            pop, push, q_full;
   fq_entry_t       q_wdata, q_head;

   // PC held in ROM-index width so increment wraps at MEM_DEPTH with no extra logic.
   assign imem_pc = ADDR_W'(fetch_pc);
   assign pop     = if_valid & if_ready;
   assign push    = fetch_en & ~redirect_valid & (~q_full | pop);
   assign q_wdata = '{pc: ADDR_W'(fetch_pc), instr: imem_data};

   // PC register: redirect wins, otherwise advance on every accepted fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              fetch_pc <= PC_W'(RESET_PC & (MEM_DEPTH - 1));
      else if (redirect_valid) fetch_pc <= PC_W'(wrap_pc(redirect_pc));
      else if (push)           fetch_pc <= fetch_pc + 1'b1;
   end

   fetch_queue #(.DEPTH(Q_DEPTH)) u_fq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (q_wdata),
      .head  (q_head),
      .valid (if_valid),
      .full  (q_full)
   );

   assign if_instr = q_head.instr;
   assign if_pc    = q_head.pc;
endmodule
